pre_mix_seq: RTL and testbench

Parametrised, sequential successor to the combinational header pre-mix. It captures a NUM_WORDS × WORD_W block with a valid/ready handshake and XOR-folds it into a single word, LANES words per cycle. It then returns every input word XORed with the mix term and holds the result until the consumer accepts it. It sits between the header assembly stage and the hash core, and bounds the XOR tree depth to LANES for timing closure.

---
 rtl/pre_mix_seq.sv | 149 ++++++++++++++
 tb/tb_pre_mix_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pre_mix_seq.sv
// Sequential header pre-mix: captures a block of words, XOR-folds it LANES words per
// cycle into a mix term, then returns every word XORed with it. Optional macro: PRE_MIX_ROT_EN.
module pre_mix_seq #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 20,
  parameter int LANES     = 4,
  parameter int ROT       = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WORDS*WORD_W-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_WORDS*WORD_W-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             mix_word,
  output logic                          busy
);

  // state | meaning
  // IDLE  | waiting for a block; in_ready high
  // FOLD  | XOR-folding LANES buffered words into acc per cycle
  // APPLY | registering buf ^ mix term into out_data / mix_word
  // HOLD  | out_valid high until the consumer takes the result

  localparam int F     = NUM_WORDS / LANES;
  localparam int IDX_W = (F > 1) ? $clog2(F) : 1;
  localparam int BLK_W = NUM_WORDS * WORD_W;

  if (LANES < 1 || (NUM_WORDS % LANES) != 0) begin : g_bad_lanes
    $error("pre_mix_seq: NUM_WORDS must be a non-zero multiple of LANES");
  end

  if (ROT < 1 || ROT > WORD_W - 1) begin : g_bad_rot
    $error("pre_mix_seq: ROT must lie in 1..WORD_W-1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FOLD  = 2'd1,
    APPLY = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   buf_q;
  logic [BLK_W-1:0]   out_data_q;
  logic [WORD_W-1:0]  acc_q;
  logic [WORD_W-1:0]  mix_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  lane_xor;
  logic [WORD_W-1:0]  mix_term;
  logic               last_fold;
  logic               load_en;
  logic               fold_en;
  logic               apply_en;

  assign last_fold = (idx_q == IDX_W'(F - 1));

  // XOR of the LANES words selected by the current fold index
  always_comb begin
    lane_xor = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_xor = lane_xor ^ buf_q[(int'(idx_q) * LANES + l) * WORD_W +: WORD_W];
    end
  end

`ifdef PRE_MIX_ROT_EN
  assign mix_term = acc_q ^ ((acc_q << ROT) | (acc_q >> (WORD_W - ROT)));
`else
  assign mix_term = acc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    fold_en   = 1'b0;
    apply_en  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = rst_n;
        if (in_valid) begin
          load_en = 1'b1;
          state_d = FOLD;
        end
      end
      FOLD: begin
        fold_en = 1'b1;
        if (last_fold) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        apply_en = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      mix_q      <= '0;
    end else begin
      if (load_en) begin
        buf_q <= in_data;
        acc_q <= '0;
        idx_q <= '0;
      end
      if (fold_en) begin
        acc_q <= acc_q ^ lane_xor;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (apply_en) begin
        out_data_q <= buf_q ^ {NUM_WORDS{mix_term}};
        mix_q      <= mix_term;
      end
    end
  end

  assign out_data = out_data_q;
  assign mix_word = mix_q;

endmodule

// File: tb/tb_pre_mix_seq.sv
// Directed bench for pre_mix_seq: default instance plus a LANES sweep (1, 2, 5, 20).
module tb_pre_mix_seq;

  localparam int WW = 32;
  localparam int NW = 20;
  localparam int BW = WW * NW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [WW-1:0] mix_word;

  logic [BW-1:0] sw_in_data;
  logic          sw_in_valid, sw_out_ready;
  logic          sw_in_ready [4];
  logic          sw_out_valid [4];
  logic          sw_busy [4];
  logic [BW-1:0] sw_out_data [4];
  logic [WW-1:0] sw_mix [4];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pre_mix_seq #(.WORD_W(WW), .NUM_WORDS(NW), .LANES(4), .ROT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mix_word(mix_word), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 20;
    pre_mix_seq #(.WORD_W(WW), .NUM_WORDS(NW), .LANES(L), .ROT(7)) u_sw (
      .clk(clk), .rst_n(rst_n),
      .in_data(sw_in_data), .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]),
      .out_data(sw_out_data[g]), .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready),
      .mix_word(sw_mix[g]), .busy(sw_busy[g])
    );
  end

  function automatic logic [WW-1:0] ref_mix(input logic [BW-1:0] b);
    logic [WW-1:0] t;
    t = '0;
    for (int i = 0; i < NW; i++) t = t ^ b[i*WW +: WW];
`ifdef PRE_MIX_ROT_EN
    return t ^ {t[WW-8:0], t[WW-1:WW-7]};
`else
    return t;
`endif
  endfunction

  function automatic logic [BW-1:0] ref_out(input logic [BW-1:0] b, input logic [WW-1:0] m);
    logic [BW-1:0] r;
    for (int i = 0; i < NW; i++) r[i*WW +: WW] = b[i*WW +: WW] ^ m;
    return r;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] b, output int lat);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [BW-1:0] blk, eo;
  logic [WW-1:0] em, mx, w0;
  int            lat;
  int            sw_lat [4];

  initial begin
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    sw_in_data = '0; sw_in_valid = 1'b0; sw_out_ready = 1'b0;

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mix", mix_word, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    send('0, lat);
    check("zero_latency", lat, 6);
    check("zero_out_data", out_data, 0);
    check("zero_mix", mix_word, 0);
    check("zero_busy", busy, 1);
    release_out();
    check("zero_in_ready_after", in_ready, 1);
    check("zero_valid_after", out_valid, 0);

`ifdef PRE_MIX_ROT_EN
    mx = 32'h0000_0081; w0 = 32'h0000_0080;
`else
    mx = 32'h0000_0001; w0 = 32'h0000_0000;
`endif
    blk = '0;
    blk[31:0] = 32'h0000_0001;
    for (int i = 0; i < NW; i++) eo[i*WW +: WW] = (i == 0) ? w0 : mx;
    send(blk, lat);
    check("w0_mix", mix_word, mx);
    check("w0_out_data", out_data, eo);
    release_out();

    blk = {NW{32'hDEAD_BEEF}};
    send(blk, lat);
    check("dead_mix", mix_word, 0);
    check("dead_out_data", out_data, blk);
    release_out();

    for (int i = 0; i < NW; i++) blk[i*WW +: WW] = $urandom;
    em = ref_mix(blk);
    eo = ref_out(blk, em);
    send(blk, lat);
    check("bp_latency", lat, 6);
    for (int c = 0; c < 10; c++) begin
      in_data  = ~blk;
      in_valid = 1'b1;
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, eo);
      check("bp_mix", mix_word, em);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();
    check("bp_in_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    check("bp_data_kept", out_data, eo);
    check("bp_mix_kept", mix_word, em);

    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) blk[i*WW +: WW] = $urandom;
    em = ref_mix(blk);
    send(blk, lat);
    check("early_rdy_latency", lat, 6);
    check("early_rdy_data", out_data, ref_out(blk, em));
    tick();
    check("early_rdy_valid_drop", out_valid, 0);
    check("early_rdy_in_ready", in_ready, 1);
    out_ready = 1'b0;

    for (int i = 0; i < NW; i++) blk[i*WW +: WW] = $urandom;
    in_data  = blk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midfold_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_mix", mix_word, 0);
    check("midrst_in_ready", in_ready, 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready_after", in_ready, 1);
    for (int i = 0; i < NW; i++) blk[i*WW +: WW] = $urandom;
    em = ref_mix(blk);
    send(blk, lat);
    check("postrst_latency", lat, 6);
    check("postrst_mix", mix_word, em);
    check("postrst_data", out_data, ref_out(blk, em));
    release_out();

    for (int i = 0; i < NW; i++) sw_in_data[i*WW +: WW] = $urandom;
    em = ref_mix(sw_in_data);
    eo = ref_out(sw_in_data, em);
    for (int g = 0; g < 4; g++) sw_lat[g] = -1;
    sw_in_valid = 1'b1;
    tick();
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int g = 0; g < 4; g++)
        if (sw_lat[g] < 0 && sw_out_valid[g]) sw_lat[g] = c;
    end
    check("sweep_l1_latency", sw_lat[0], 21);
    check("sweep_l2_latency", sw_lat[1], 11);
    check("sweep_l5_latency", sw_lat[2], 5);
    check("sweep_l20_latency", sw_lat[3], 2);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sweep%0d_data", g), sw_out_data[g], eo);
      check($sformatf("sweep%0d_mix", g), sw_mix[g], em);
    end
    sw_out_ready = 1'b1;
    tick();
    sw_out_ready = 1'b0;
    for (int g = 0; g < 4; g++) check($sformatf("sweep%0d_in_ready", g), sw_in_ready[g], 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
